// File: rtl/rx_sync_pkg.sv
// Shared definitions for the two-lane comma-alignment receiver.
package rx_sync_pkg;

   typedef enum logic [1:0] {
      ST_UNSYNC = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_SYNC   = 2'd2
   } sync_state_t;

   localparam logic [7:0] COMMA_DEF    = 8'hBC;
   localparam int         SYNC_CNT_DEF = 4;

endpackage

// File: rtl/rx_lane_sync.sv
// One serial lane: bit shifter, comma hunt, word alignment and word strobe.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_UNSYNC | hunting for COMMA at any bit offset
//   ST_ALIGN  | offset locked, counting commas on consecutive word boundaries
//   ST_SYNC   | aligned; every 8th edge strobes the received word
module rx_lane_sync
   import rx_sync_pkg::*;
#(
   parameter logic [7:0] COMMA    = COMMA_DEF,
   parameter int         SYNC_CNT = SYNC_CNT_DEF
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       i_data,
   input  logic       i_en,
   output logic [7:0] o_word,
   output logic       o_stb,
   output logic       o_valid,
   output logic       o_sync
);

   localparam logic [3:0] SYNC_CNT_L = 4'(SYNC_CNT);

   sync_state_t r_state;
   logic [7:0]  r_sh;
   logic [2:0]  r_bc;
   logic [3:0]  r_cc;
   logic [7:0]  r_word;
   logic        r_stb;
   logic        r_valid;

   sync_state_t w_state_nxt;
   logic [7:0]  w_sh_nxt;
   logic [2:0]  w_bc_nxt;
   logic [3:0]  w_cc_nxt;
   logic [7:0]  w_word_nxt;
   logic        w_stb_nxt;
   logic        w_valid_nxt;

   logic [7:0]  w_shift;
   logic        w_comma;
   logic        w_boundary;
   logic [3:0]  w_cc_inc;

   assign w_shift    = {r_sh[6:0], i_data};
   assign w_comma    = (w_shift == COMMA);
   assign w_boundary = (r_bc == 3'd7);
   assign w_cc_inc   = r_cc + 4'd1;

   // Next-state and next-output decode; a disabled lane freezes its shifter and word.
   always_comb begin
      w_state_nxt = r_state;
      w_sh_nxt    = r_sh;
      w_bc_nxt    = r_bc;
      w_cc_nxt    = r_cc;
      w_word_nxt  = r_word;
      w_stb_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
      if (!i_en) begin
         w_state_nxt = ST_UNSYNC;
         w_bc_nxt    = 3'd0;
         w_cc_nxt    = 4'd0;
      end else begin
         w_sh_nxt = w_shift;
         case (r_state)
            ST_UNSYNC: begin
               if (w_comma) begin
                  w_bc_nxt    = 3'd0;
                  w_cc_nxt    = 4'd1;
                  w_state_nxt = (SYNC_CNT == 1) ? ST_SYNC : ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               w_bc_nxt = r_bc + 3'd1;
               if (w_boundary) begin
                  if (w_comma) begin
                     w_cc_nxt = w_cc_inc;
                     if (w_cc_inc == SYNC_CNT_L) begin
                        w_state_nxt = ST_SYNC;
                     end
                  end else begin
                     w_state_nxt = ST_UNSYNC;
                     w_cc_nxt    = 4'd0;
                  end
               end
            end
            ST_SYNC: begin
               // Data content never drops sync; only reset or disable does.
               w_bc_nxt = r_bc + 3'd1;
               if (w_boundary) begin
                  w_word_nxt  = w_shift;
                  w_stb_nxt   = 1'b1;
                  w_valid_nxt = !w_comma;
               end
            end
            default: begin
               w_state_nxt = ST_UNSYNC;
               w_bc_nxt    = 3'd0;
               w_cc_nxt    = 4'd0;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_8f) begin
      if (reset) begin
         r_state <= ST_UNSYNC;
         r_sh    <= 8'h00;
         r_bc    <= 3'd0;
         r_cc    <= 4'd0;
         r_word  <= 8'h00;
         r_stb   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sh    <= w_sh_nxt;
         r_bc    <= w_bc_nxt;
         r_cc    <= w_cc_nxt;
         r_word  <= w_word_nxt;
         r_stb   <= w_stb_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign o_word  = r_word;
   assign o_stb   = r_stb;
   assign o_valid = r_valid;
   assign o_sync  = (r_state == ST_SYNC);

endmodule

// File: rtl/rx_sync_ctrl.sv
// Two independent comma-aligned serial lanes plus the combined link-active flag.
module rx_sync_ctrl
   import rx_sync_pkg::*;
#(
   parameter logic [7:0] COMMA    = COMMA_DEF,
   parameter int         SYNC_CNT = SYNC_CNT_DEF
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       data_in_c_0,
   input  logic       data_in_c_1,
   input  logic [1:0] lane_en,
   output logic [7:0] word_c_0,
   output logic [7:0] word_c_1,
   output logic       stb_c_0,
   output logic       stb_c_1,
   output logic       valid_c_0,
   output logic       valid_c_1,
   output logic [1:0] sync_c,
   output logic       active
);

   logic [1:0] w_sync;

   rx_lane_sync #(.COMMA(COMMA), .SYNC_CNT(SYNC_CNT)) u_lane0 (
      .clk_8f  (clk_8f),
      .reset   (reset),
      .i_data  (data_in_c_0),
      .i_en    (lane_en[0]),
      .o_word  (word_c_0),
      .o_stb   (stb_c_0),
      .o_valid (valid_c_0),
      .o_sync  (w_sync[0])
   );

   rx_lane_sync #(.COMMA(COMMA), .SYNC_CNT(SYNC_CNT)) u_lane1 (
      .clk_8f  (clk_8f),
      .reset   (reset),
      .i_data  (data_in_c_1),
      .i_en    (lane_en[1]),
      .o_word  (word_c_1),
      .o_stb   (stb_c_1),
      .o_valid (valid_c_1),
      .o_sync  (w_sync[1])
   );

   assign sync_c = w_sync;
   assign active = &w_sync;

endmodule
